// File: rtl/otp_read_verify.sv
// ---------------------------------------------------------------------------
// otp_read_verify
//
// Read/verify back end for the OTP array. The array controller FSM applies the
// read bias and raises read_active. This block does the following:
//   - latches the column, the verify request and the expected word;
//   - waits SETTLE cycles for the sense lines to settle;
//   - takes SAMPLES samples of every row comparator;
//   - majority-votes each row and presents the voted word on data_out.
// For a program-verify it also compares the voted word with the word just
// programmed. It reports the result on writing_successful and fail_mask.
//
// Parameters
//   A        rows / word width (one sense comparator per row)
//   B        columns; column select width is $clog2(B)
//   SETTLE   settle cycles after acquisition start (0 allowed)
//   SAMPLES  samples per bit; must be odd and >= 1
//
// Ports
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous, active-low reset
//   read_active         in   read bias applied, sense lines valid
//   column              in   column under read (latched at acquisition start)
//   sense_in            in   sense comparator outputs, bit r = row r
//   verify_req          in   acquisition is a program-verify (latched at start)
//   expected            in   word just programmed (latched at start)
//   data_out            out  voted read word
//   data_valid          out  1-cycle pulse: data_out updated
//   writing_successful  out  level: last verify passed
//   fail_mask           out  bits where voted data != expected (verify only)
//   col_out             out  column that data_out belongs to
//   busy                out  acquisition in progress (SETTLE/SAMPLE/VOTE)
//   aborted             out  1-cycle pulse: read_active dropped mid-acquisition
// ---------------------------------------------------------------------------
module otp_read_verify #(
  parameter int A       = 2,
  parameter int B       = 2,
  parameter int SETTLE  = 2,
  parameter int SAMPLES = 3,
  localparam int CW     = (B > 1) ? $clog2(B) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read_active,
  input  logic [CW-1:0] column,
  input  logic [A-1:0]  sense_in,
  input  logic          verify_req,
  input  logic [A-1:0]  expected,
  output logic [A-1:0]  data_out,
  output logic          data_valid,
  output logic          writing_successful,
  output logic [A-1:0]  fail_mask,
  output logic [CW-1:0] col_out,
  output logic          busy,
  output logic          aborted
);

  // An even sample count could tie the vote, so it is rejected at elaboration.
  if ((SAMPLES < 1) || ((SAMPLES % 2) == 0)) begin : g_bad_samples
    $error("otp_read_verify: SAMPLES must be odd and >= 1");
  end

  // Counter widths. Each counter counts 0..N-1, and is always at least 1 bit.
  localparam int CNTW = $clog2(SAMPLES + 1);
  localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SCW  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  localparam logic [SW-1:0]   SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [SCW-1:0]  SAMPLE_LAST = SCW'(SAMPLES - 1);
  localparam logic [CNTW-1:0] VOTE_HALF   = CNTW'(SAMPLES / 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_VOTE,
    ST_DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   settle_cnt;
  logic [SCW-1:0]  sample_cnt;
  logic [CNTW-1:0] ones_cnt [A];
  logic [CW-1:0]   col_lat;
  logic            verify_lat;
  logic [A-1:0]    expected_lat;
  logic [A-1:0]    voted;

  // A row reads as 1 when strictly more than half of its samples were 1.
  always_comb begin
    voted = '0;
    for (int r = 0; r < A; r++) begin
      voted[r] = (ones_cnt[r] > VOTE_HALF);
    end
  end

  // The acquisition FSM. All outputs are registered here.
  // - data_valid and aborted are pulses. They default low every cycle and are
  //   raised only on the VOTE edge and the abort edge. Those two edges are
  //   mutually exclusive, so the pulses can never coincide.
  // - writing_successful is cleared at acquisition start. An aborted or plain
  //   read therefore leaves it low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      settle_cnt         <= '0;
      sample_cnt         <= '0;
      col_lat            <= '0;
      verify_lat         <= 1'b0;
      expected_lat       <= '0;
      data_out           <= '0;
      data_valid         <= 1'b0;
      writing_successful <= 1'b0;
      fail_mask          <= '0;
      col_out            <= '0;
      busy               <= 1'b0;
      aborted            <= 1'b0;
      for (int r = 0; r < A; r++) begin
        ones_cnt[r] <= '0;
      end
    end else begin
      data_valid <= 1'b0;
      aborted    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read_active) begin
            col_lat            <= column;
            verify_lat         <= verify_req;
            expected_lat       <= expected;
            writing_successful <= 1'b0;
            settle_cnt         <= '0;
            sample_cnt         <= '0;
            busy               <= 1'b1;
            for (int r = 0; r < A; r++) begin
              ones_cnt[r] <= '0;
            end
            state <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (!read_active) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        // Losing the bias during sampling makes the samples untrustworthy.
        // An abort therefore skips accumulation on that edge.
        ST_SAMPLE: begin
          if (!read_active) begin
            aborted <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            for (int r = 0; r < A; r++) begin
              ones_cnt[r] <= ones_cnt[r] + CNTW'(sense_in[r]);
            end
            if (sample_cnt == SAMPLE_LAST) begin
              state <= ST_VOTE;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end

        ST_VOTE: begin
          data_out   <= voted;
          col_out    <= col_lat;
          data_valid <= 1'b1;
          busy       <= 1'b0;
          if (verify_lat) begin
            fail_mask          <= voted ^ expected_lat;
            writing_successful <= (voted == expected_lat);
          end else begin
            fail_mask          <= '0;
            writing_successful <= 1'b0;
          end
          state <= ST_DONE;
        end

        // A fresh rising level is needed before the next acquisition can start.
        ST_DONE: begin
          if (!read_active) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otp_read_verify.sv
// ---------------------------------------------------------------------------
// tb_otp_read_verify
//
// Self-checking bench for otp_read_verify with A=8, B=8, SETTLE=2, SAMPLES=3.
// The bench applies three kinds of stimulus:
//   - a table of directed acquisitions with hand-computed results;
//   - hand-written reset and hold-in-DONE sequences;
//   - randomized acquisitions checked against a behavioural majority model.
// ---------------------------------------------------------------------------
module tb_otp_read_verify;

  localparam int A       = 8;
  localparam int B       = 8;
  localparam int SETTLE  = 2;
  localparam int SAMPLES = 3;
  localparam int LAT     = SETTLE + SAMPLES + 1;

  logic       clk;
  logic       reset;
  logic       read_active;
  logic [2:0] column;
  logic [7:0] sense_in;
  logic       verify_req;
  logic [7:0] expected;
  logic [7:0] data_out;
  logic       data_valid;
  logic       writing_successful;
  logic [7:0] fail_mask;
  logic [2:0] col_out;
  logic       busy;
  logic       aborted;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected state of the DUT outputs as seen by the reference model.
  logic [7:0] m_data;
  logic [2:0] m_col;
  logic [7:0] m_fail;
  logic       m_ws;

  typedef struct {
    logic [2:0]      col;
    logic            vfy;
    logic [7:0]      exp_word;
    logic [2:0][7:0] samp;
    int              abort_edge;
    logic [7:0]      e_data;
    logic [2:0]      e_col;
    logic [7:0]      e_fail;
    logic            e_ws;
  } vec_t;

  vec_t vecs [8];

  otp_read_verify #(
    .A(A), .B(B), .SETTLE(SETTLE), .SAMPLES(SAMPLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read_active(read_active),
    .column(column),
    .sense_in(sense_in),
    .verify_req(verify_req),
    .expected(expected),
    .data_out(data_out),
    .data_valid(data_valid),
    .writing_successful(writing_successful),
    .fail_mask(fail_mask),
    .col_out(col_out),
    .busy(busy),
    .aborted(aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [2:0][7:0] pack3(input logic [7:0] s0, input logic [7:0] s1,
                                            input logic [7:0] s2);
    return {s2, s1, s0};
  endfunction

  // Majority per bit: a bit is 1 when it is 1 in more than half of the samples.
  function automatic logic [7:0] model_vote(input logic [2:0][7:0] s);
    logic [7:0] v;
    int ones;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int k = 0; k < SAMPLES; k++) begin
        ones += int'(s[k][b]);
      end
      v[b] = (2 * ones > SAMPLES);
    end
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check_output({tag, ".data_out"}, 32'(data_out), 32'(m_data));
    check_output({tag, ".col_out"}, 32'(col_out), 32'(m_col));
    check_output({tag, ".fail_mask"}, 32'(fail_mask), 32'(m_fail));
    check_output({tag, ".ws"}, 32'(writing_successful), 32'(m_ws));
    check_output({tag, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  // Runs one acquisition.
  // - Edge E0 is the first edge at which read_active is high.
  // - Sample k is presented for edge E(SETTLE+1+k).
  // - With abort_edge >= 0, read_active is low from that edge onwards.
  // - Latched inputs are scrambled right after E0 to prove they are ignored.
  task automatic apply_stimulus(input logic [2:0] col, input logic vfy, input logic [7:0] exp_word,
                                input logic [2:0][7:0] samp, input int abort_edge);
    int last;
    int nxt;
    logic [7:0] voted;
    last = (abort_edge >= 0) ? abort_edge + 1 : LAT;
    @(negedge clk);
    read_active = 1'b1;
    column      = col;
    verify_req  = vfy;
    expected    = exp_word;
    sense_in    = 8'($urandom);
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      check_output("seq.data_valid", 32'(data_valid), 32'((abort_edge < 0) && (k == LAT)));
      check_output("seq.aborted", 32'(aborted), 32'(k == abort_edge));
      check_output("seq.busy", 32'(busy),
                   32'((abort_edge >= 0) ? (k < abort_edge) : (k < LAT)));
      nxt = k + 1;
      if (k == 0) begin
        column     = 3'($urandom);
        verify_req = ~vfy;
        expected   = 8'($urandom);
      end
      if (nxt > SETTLE && nxt <= SETTLE + SAMPLES) begin
        sense_in = samp[nxt - SETTLE - 1];
      end else begin
        sense_in = 8'($urandom);
      end
      read_active = (abort_edge >= 0 && nxt >= abort_edge) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    read_active = 1'b0;
    @(posedge clk);
    #1;
    if (abort_edge < 0) begin
      voted  = model_vote(samp);
      m_data = voted;
      m_col  = col;
      m_fail = vfy ? (voted ^ exp_word) : 8'h00;
      m_ws   = vfy && (voted == exp_word);
    end else begin
      m_ws = 1'b0;
    end
  endtask

  initial begin
    int dv_count;
    logic [7:0] w;
    logic [7:0] e;
    logic [2:0][7:0] s;
    int ab;

    reset       = 1'b0;
    read_active = 1'b0;
    column      = '0;
    sense_in    = '0;
    verify_req  = 1'b0;
    expected    = '0;
    m_data = '0; m_col = '0; m_fail = '0; m_ws = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    check_output("reset.data_valid", 32'(data_valid), 32'd0);
    check_output("reset.aborted", 32'(aborted), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table: plain read, majority, verify pass/fail, aborts.
    vecs[0] = '{3'd5, 1'b0, 8'h00, pack3(8'hA5, 8'hA5, 8'hA5), -1, 8'hA5, 3'd5, 8'h00, 1'b0};
    vecs[1] = '{3'd0, 1'b0, 8'h00, pack3(8'h01, 8'h80, 8'h01), -1, 8'h01, 3'd0, 8'h00, 1'b0};
    vecs[2] = '{3'd6, 1'b1, 8'hAE, pack3(8'hAE, 8'hAE, 8'hAE), -1, 8'hAE, 3'd6, 8'h00, 1'b1};
    vecs[3] = '{3'd2, 1'b1, 8'hAE, pack3(8'hAC, 8'hAC, 8'hAC), -1, 8'hAC, 3'd2, 8'h02, 1'b0};
    vecs[4] = '{3'd3, 1'b0, 8'h00, pack3(8'hFF, 8'hFF, 8'hFF),  4, 8'hAC, 3'd2, 8'h02, 1'b0};
    vecs[5] = '{3'd1, 1'b0, 8'h00, pack3(8'h3C, 8'h3C, 8'h3C), -1, 8'h3C, 3'd1, 8'h00, 1'b0};
    vecs[6] = '{3'd7, 1'b1, 8'h5A, pack3(8'h5A, 8'h5B, 8'hDA), -1, 8'h5A, 3'd7, 8'h00, 1'b1};
    vecs[7] = '{3'd4, 1'b1, 8'h00, pack3(8'h11, 8'h11, 8'h11),  2, 8'h5A, 3'd7, 8'h00, 1'b0};

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].col, vecs[i].vfy, vecs[i].exp_word, vecs[i].samp, vecs[i].abort_edge);
      check_output($sformatf("vec%0d.data_out", i), 32'(data_out), 32'(vecs[i].e_data));
      check_output($sformatf("vec%0d.col_out", i), 32'(col_out), 32'(vecs[i].e_col));
      check_output($sformatf("vec%0d.fail_mask", i), 32'(fail_mask), 32'(vecs[i].e_fail));
      check_output($sformatf("vec%0d.ws", i), 32'(writing_successful), 32'(vecs[i].e_ws));
      check_output($sformatf("vec%0d.busy", i), 32'(busy), 32'd0);
    end

    // read_active held high through DONE: exactly one data_valid pulse.
    @(negedge clk);
    read_active = 1'b1;
    column      = 3'd6;
    verify_req  = 1'b0;
    sense_in    = 8'h77;
    dv_count    = 0;
    for (int k = 0; k < LAT + 11; k++) begin
      @(posedge clk);
      #1;
      if (data_valid) dv_count++;
    end
    check_output("hold.dv_count", 32'(dv_count), 32'd1);
    check_output("hold.busy", 32'(busy), 32'd0);
    check_output("hold.data_out", 32'(data_out), 32'h77);
    @(negedge clk);
    read_active = 1'b0;
    @(posedge clk);
    #1;
    m_data = 8'h77; m_col = 3'd6; m_fail = 8'h00; m_ws = 1'b0;

    // Verify pass so that writing_successful is high going into the reset test.
    apply_stimulus(3'd3, 1'b1, 8'hC3, pack3(8'hC3, 8'hC3, 8'hC3), -1);
    check_model("pre_reset");

    // Async reset between edges in SAMPLE.
    @(negedge clk);
    read_active = 1'b1;
    column      = 3'd5;
    sense_in    = 8'hFF;
    repeat (SETTLE + 2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    m_data = '0; m_col = '0; m_fail = '0; m_ws = 1'b0;
    check_model("async_reset");
    check_output("async_reset.data_valid", 32'(data_valid), 32'd0);
    @(negedge clk);
    read_active = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(3'd2, 1'b0, 8'h00, pack3(8'h96, 8'h96, 8'h96), -1);
    check_model("post_reset");

    // Randomized acquisitions against the majority model.
    for (int i = 0; i < 40; i++) begin
      w = 8'($urandom);
      for (int k = 0; k < SAMPLES; k++) begin
        s[k] = w ^ 8'($urandom & $urandom & $urandom);
      end
      e  = ($urandom_range(0, 1) == 1) ? w : (w ^ (8'h01 << $urandom_range(0, 7)));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SETTLE + SAMPLES)) : -1;
      apply_stimulus(3'($urandom), 1'($urandom), e, s, ab);
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
